uart_tx_fifo_engine: RTL and testbench

Parametrised UART transmit engine for the CECS 460 UART datapath: a synchronous FIFO buffers bytes from the host side, and a frame FSM serialises them onto `tx`. It supports runtime-selected baud rate, 7/8 data bits, optional odd/even parity and 1/2 stop bits. It is the buffered, generalised successor to the single-byte TXRDY transmitter and sits between the host write port and the board `tx` pin.

---
 rtl/uart_pkg.sv | 37 +++
 rtl/sync_fifo.sv | 68 ++++++
 rtl/uart_tx_fifo_engine.sv | 176 +++++++++++++++++
 tb/tb_uart_tx_fifo_engine.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and helpers for the buffered UART transmitter: baud table,
// bit-period calculation, frame FSM states and the per-frame configuration.
package uart_pkg;

    localparam int unsigned PERIOD_W   = 24;
    localparam int unsigned BAUD_CODES = 16;

    localparam int unsigned BAUD_RATE [BAUD_CODES] = '{
        300, 1200, 2400, 4800, 9600, 19200, 38400, 57600,
        115200, 230400, 460800, 921600, 921600, 921600, 921600, 921600
    };

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } tx_state_e;

    typedef struct packed {
        logic                eight;
        logic                parity_en;
        logic                odd_n_even;
        logic                two_stop;
        logic [PERIOD_W-1:0] period;
    } frame_cfg_t;

    // Rounded number of clocks per bit for a rate code.
    function automatic logic [PERIOD_W-1:0] bit_clocks(input int unsigned clk_hz,
                                                       input logic [3:0]  code);
        int unsigned rate;
        rate = BAUD_RATE[code];
        return PERIOD_W'((clk_hz + rate / 2) / rate);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered occupancy, full and empty flags.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic                     i_wr_en,
    input  logic [WIDTH-1:0]         i_wr_data,
    input  logic                     i_rd_en,
    output logic [WIDTH-1:0]         o_rd_data_c,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic [CW-1:0]    w_count_nxt;
    logic             r_full;
    logic             r_empty;
    logic             w_wr;
    logic             w_rd;

    // Full is judged on the current occupancy, so a same-cycle pop never admits a write.
    assign w_wr = i_wr_en && !r_full;
    assign w_rd = i_rd_en && !r_empty;

    always_comb begin
        w_count_nxt = r_count;
        case ({w_wr, w_rd})
            2'b10:   w_count_nxt = r_count + CW'(1);
            2'b01:   w_count_nxt = r_count - CW'(1);
            default: w_count_nxt = r_count;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
        end else begin
            if (w_wr) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_rd) r_rd_ptr <= r_rd_ptr + AW'(1);
            r_count <= w_count_nxt;
            r_full  <= (w_count_nxt == CW'(DEPTH));
            r_empty <= (w_count_nxt == '0);
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_wr) r_mem[r_wr_ptr] <= i_wr_data;
    end

    assign o_rd_data_c = r_mem[r_rd_ptr];
    assign o_full      = r_full;
    assign o_empty     = r_empty;
    assign o_count     = r_count;

endmodule

// File: rtl/uart_tx_fifo_engine.sv
// Buffered UART transmitter: host bytes queue in a FIFO and a frame FSM
// serialises them onto o_tx with per-frame baud, width, parity and stop config.
module uart_tx_fifo_engine
    import uart_pkg::*;
#(
    parameter int unsigned CLK_HZ     = 100_000_000,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic                          i_clk,
    input  logic                          i_reset,
    input  logic [3:0]                    i_baud,
    input  logic                          i_eight,
    input  logic                          i_parity_en,
    input  logic                          i_odd_n_even,
    input  logic                          i_two_stop,
    input  logic                          i_wr_en,
    input  logic [7:0]                    i_wr_data,
    output logic                          o_tx_rdy,
    output logic                          o_full,
    output logic                          o_empty,
    output logic [$clog2(FIFO_DEPTH):0]   o_count,
    output logic                          o_overflow,
    output logic                          o_busy,
    output logic                          o_tx
);

    tx_state_e           r_state;
    tx_state_e           w_state_nxt;
    frame_cfg_t          r_cfg;
    frame_cfg_t          w_cfg_nxt;
    logic [7:0]          r_shift;
    logic [7:0]          w_shift_nxt;
    logic                r_par;
    logic                w_par_nxt;
    logic [PERIOD_W-1:0] r_baud_cnt;
    logic [PERIOD_W-1:0] w_baud_cnt_nxt;
    logic [2:0]          r_bit_cnt;
    logic [2:0]          w_bit_cnt_nxt;
    logic                r_tx;
    logic                w_tx_nxt;
    logic                r_busy;
    logic                r_overflow;
    logic                w_pop;
    logic                w_tick;
    logic                w_last_data;
    logic                w_full;
    logic                w_empty;
    logic [7:0]          w_rd_data;
    logic [7:0]          w_data_in;
    logic [PERIOD_W-1:0] w_period_lut [BAUD_CODES];
    logic [PERIOD_W-1:0] w_new_period;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_wr_en     (i_wr_en),
        .i_wr_data   (i_wr_data),
        .i_rd_en     (w_pop),
        .o_rd_data_c (w_rd_data),
        .o_full      (w_full),
        .o_empty     (w_empty),
        .o_count     (o_count)
    );

    // Bit periods are elaboration-time constants; the rate code only selects one.
    for (genvar g = 0; g < BAUD_CODES; g++) begin : g_period
        assign w_period_lut[g] = bit_clocks(CLK_HZ, 4'(g));
    end

    assign w_new_period = w_period_lut[i_baud];
    assign w_data_in    = i_eight ? w_rd_data : {1'b0, w_rd_data[6:0]};
    assign w_tick       = (r_baud_cnt == '0);
    assign w_last_data  = (r_bit_cnt == (r_cfg.eight ? 3'd7 : 3'd6));

    always_ff @(posedge i_clk) begin
        if (i_reset) r_state <= ST_IDLE;
        else         r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_cfg_nxt      = r_cfg;
        w_shift_nxt    = r_shift;
        w_par_nxt      = r_par;
        w_baud_cnt_nxt = r_baud_cnt;
        w_bit_cnt_nxt  = r_bit_cnt;
        w_tx_nxt       = 1'b1;
        w_pop          = 1'b0;

        if (r_state != ST_IDLE) begin
            w_baud_cnt_nxt = w_tick ? (r_cfg.period - PERIOD_W'(1)) : (r_baud_cnt - PERIOD_W'(1));
        end

        case (r_state)
            ST_IDLE: begin
                if (!w_empty) w_pop = 1'b1;
            end
            ST_START: begin
                w_tx_nxt = 1'b0;
                if (w_tick) w_state_nxt = ST_DATA;
            end
            ST_DATA: begin
                w_tx_nxt = r_shift[0];
                if (w_tick) begin
                    w_shift_nxt = {1'b0, r_shift[7:1]};
                    if (w_last_data) begin
                        w_bit_cnt_nxt = '0;
                        w_state_nxt   = r_cfg.parity_en ? ST_PARITY : ST_STOP;
                    end else begin
                        w_bit_cnt_nxt = r_bit_cnt + 3'd1;
                    end
                end
            end
            ST_PARITY: begin
                w_tx_nxt = r_par ^ r_cfg.odd_n_even;
                if (w_tick) w_state_nxt = ST_STOP;
            end
            ST_STOP: begin
                // r_bit_cnt marks the first of two stop bits as already sent.
                if (w_tick) begin
                    if (r_cfg.two_stop && (r_bit_cnt == '0)) w_bit_cnt_nxt = 3'd1;
                    else if (!w_empty)                       w_pop         = 1'b1;
                    else                                     w_state_nxt   = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase

        // A pop latches the next frame's byte and config and starts its start bit.
        if (w_pop) begin
            w_state_nxt          = ST_START;
            w_cfg_nxt.eight      = i_eight;
            w_cfg_nxt.parity_en  = i_parity_en;
            w_cfg_nxt.odd_n_even = i_odd_n_even;
            w_cfg_nxt.two_stop   = i_two_stop;
            w_cfg_nxt.period     = w_new_period;
            w_shift_nxt          = w_data_in;
            w_par_nxt            = ^w_data_in;
            w_baud_cnt_nxt       = w_new_period - PERIOD_W'(1);
            w_bit_cnt_nxt        = '0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_cfg      <= '0;
            r_shift    <= '0;
            r_par      <= 1'b0;
            r_baud_cnt <= '0;
            r_bit_cnt  <= '0;
            r_tx       <= 1'b1;
            r_busy     <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_cfg      <= w_cfg_nxt;
            r_shift    <= w_shift_nxt;
            r_par      <= w_par_nxt;
            r_baud_cnt <= w_baud_cnt_nxt;
            r_bit_cnt  <= w_bit_cnt_nxt;
            r_tx       <= w_tx_nxt;
            r_busy     <= (r_state != ST_IDLE);
            r_overflow <= r_overflow | (i_wr_en & w_full);
        end
    end

    assign o_tx_rdy   = ~w_full;
    assign o_full     = w_full;
    assign o_empty    = w_empty;
    assign o_overflow = r_overflow;
    assign o_busy     = r_busy;
    assign o_tx       = r_tx;

endmodule

// File: tb/tb_uart_tx_fifo_engine.sv
// Scoreboard bench for uart_tx_fifo_engine: stimulus pushes hand-computed frames,
// a line monitor checks every cycle of every bit on tx against them.
module tb_uart_tx_fifo_engine;

    localparam int unsigned CLK_HZ = 100_000_000;
    localparam int unsigned DEPTH  = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] baud;
    logic       eight;
    logic       parity_en;
    logic       odd_n_even;
    logic       two_stop;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       o_tx_rdy;
    logic       o_full;
    logic       o_empty;
    logic [2:0] o_count;
    logic       o_overflow;
    logic       o_busy;
    logic       o_tx;

    typedef struct {
        logic [11:0] bits;
        int          nbits;
        int          period;
        bit          b2b;
        bit          chk_lat;
        longint      wr_cyc;
    } exp_t;

    exp_t   sb_q[$];
    int     n_checks = 0;
    int     n_err    = 0;
    longint cyc      = 0;
    bit     abort    = 1'b0;
    bit     mon_active = 1'b0;

    uart_tx_fifo_engine #(
        .CLK_HZ     (CLK_HZ),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .i_clk        (clk),
        .i_reset      (reset),
        .i_baud       (baud),
        .i_eight      (eight),
        .i_parity_en  (parity_en),
        .i_odd_n_even (odd_n_even),
        .i_two_stop   (two_stop),
        .i_wr_en      (wr_en),
        .i_wr_data    (wr_data),
        .o_tx_rdy     (o_tx_rdy),
        .o_full       (o_full),
        .o_empty      (o_empty),
        .o_count      (o_count),
        .o_overflow   (o_overflow),
        .o_busy       (o_busy),
        .o_tx         (o_tx)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input bit ok, input string name, input longint act, input longint exp);
        n_checks++;
        if (!ok) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_exp(input logic [11:0] bits, input int nbits, input int period,
                            input bit b2b, input bit chk_lat, input longint wc);
        exp_t e;
        e.bits = bits; e.nbits = nbits; e.period = period;
        e.b2b = b2b; e.chk_lat = chk_lat; e.wr_cyc = wc;
        sb_q.push_back(e);
    endtask

    // Called in the slot just after a rising edge; returns the edge index of the write.
    task automatic write_byte(input logic [7:0] d, output longint wc);
        wr_en = 1'b1;
        wr_data = d;
        @(posedge clk); #1;
        wc = cyc;
        wr_en = 1'b0;
    endtask

    task automatic wait_idle(input int max_cyc, input string name);
        int n = 0;
        while ((sb_q.size() != 0 || mon_active || o_busy !== 1'b0) && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        check(n < max_cyc, {name, "_idle_timeout"}, n, max_cyc);
        repeat (3) @(negedge clk);
        @(posedge clk); #1;
    endtask

    // Line monitor: decodes frames from tx and compares each bit period cycle-by-cycle.
    initial begin : monitor
        int   gap;
        bit   post;
        bit   bit_ok;
        bit   aborted;
        int   nbad;
        exp_t e;
        gap  = 1000;
        post = 1'b0;
        forever begin
            @(negedge clk);
            if (abort) begin
                post = 1'b0;
                gap  = 1000;
                mon_active = 1'b0;
            end else if (o_tx === 1'b0) begin
                post = 1'b0;
                check(sb_q.size() != 0, "start_expected", sb_q.size(), 1);
                if (sb_q.size() == 0) begin
                    while (o_tx === 1'b0 && !abort) @(negedge clk);
                end else begin
                    mon_active = 1'b1;
                    e = sb_q.pop_front();
                    if (e.b2b)     check(gap == 0, "b2b_gap", gap, 0);
                    if (e.chk_lat) check(cyc == e.wr_cyc + 2, "start_latency", cyc - e.wr_cyc, 2);
                    check(o_busy === 1'b1, "busy_rise", o_busy, 1);
                    aborted = 1'b0;
                    for (int i = 0; i < e.nbits && !aborted; i++) begin
                        bit_ok = 1'b1;
                        nbad   = 0;
                        for (int c = 0; c < e.period; c++) begin
                            if (i != 0 || c != 0) @(negedge clk);
                            if (abort) begin
                                aborted = 1'b1;
                                break;
                            end
                            if (o_tx !== e.bits[i]) begin
                                bit_ok = 1'b0;
                                nbad++;
                            end
                        end
                        if (!aborted)
                            check(bit_ok, $sformatf("frame_bit%0d_bad_cycles(level %0b)", i, e.bits[i]), nbad, 0);
                    end
                    mon_active = 1'b0;
                    gap  = aborted ? 1000 : 0;
                    post = !aborted;
                end
            end else begin
                if (post) check(o_busy === 1'b0, "busy_fall", o_busy, 0);
                post = 1'b0;
                gap++;
            end
        end
    end

    initial begin : stim
        longint     wc;
        logic [7:0] t4_bytes [6];
        t4_bytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};

        reset = 1'b1; wr_en = 1'b0; wr_data = 8'h00;
        baud = 4'd8; eight = 1'b1; parity_en = 1'b0; odd_n_even = 1'b0; two_stop = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check(o_tx === 1'b1,       "rst_tx",       o_tx,       1);
        check(o_busy === 1'b0,     "rst_busy",     o_busy,     0);
        check(o_empty === 1'b1,    "rst_empty",    o_empty,    1);
        check(o_full === 1'b0,     "rst_full",     o_full,     0);
        check(o_tx_rdy === 1'b1,   "rst_tx_rdy",   o_tx_rdy,   1);
        check(o_count === 3'd0,    "rst_count",    o_count,    0);
        check(o_overflow === 1'b0, "rst_overflow", o_overflow, 0);
        reset = 1'b0;
        @(posedge clk); #1;

        // 115200 8N1, 0x55
        write_byte(8'h55, wc);
        push_exp({2'b00, 1'b1, 8'h55, 1'b0}, 10, 868, 1'b0, 1'b1, wc);
        check(o_count === 3'd1,  "t1_count_after_write", o_count, 1);
        check(o_empty === 1'b0,  "t1_empty_after_write", o_empty, 0);
        @(posedge clk); #1;
        check(o_count === 3'd0,  "t1_count_after_pop", o_count, 0);
        check(o_busy === 1'b0,   "t1_busy_at_pop",     o_busy,  0);
        check(o_tx === 1'b1,     "t1_tx_at_pop",       o_tx,    1);
        @(posedge clk); #1;
        check(o_busy === 1'b1,   "t1_busy_at_start",   o_busy,  1);
        check(o_tx === 1'b0,     "t1_tx_at_start",     o_tx,    0);
        wait_idle(20000, "t1");

        // 921600 (109 clocks/bit), 7E1, 0x83 -> data 1100000, parity 0
        baud = 4'd11; eight = 1'b0; parity_en = 1'b1; odd_n_even = 1'b0; two_stop = 1'b0;
        write_byte(8'h83, wc);
        push_exp({2'b00, 1'b1, 1'b0, 7'h03, 1'b0}, 10, 109, 1'b0, 1'b1, wc);
        wait_idle(5000, "t2");

        // 8O2, 0xFF -> parity 1, two stop bits
        eight = 1'b1; parity_en = 1'b1; odd_n_even = 1'b1; two_stop = 1'b1;
        write_byte(8'hFF, wc);
        push_exp(12'hFFE, 12, 109, 1'b0, 1'b1, wc);
        wait_idle(5000, "t3");

        // Six consecutive writes into a depth-4 FIFO: sixth is dropped
        parity_en = 1'b0; odd_n_even = 1'b0; two_stop = 1'b0;
        for (int k = 0; k < 6; k++) begin
            wr_en = 1'b1;
            wr_data = t4_bytes[k];
            @(posedge clk); #1;
            if (k < 5) push_exp({2'b00, 1'b1, t4_bytes[k], 1'b0}, 10, 109, k > 0, k == 0, cyc);
            if (k == 0) check(o_count === 3'd1, "t4_count_first", o_count, 1);
            if (k == 4) begin
                check(o_full === 1'b1,   "t4_full",   o_full,   1);
                check(o_tx_rdy === 1'b0, "t4_tx_rdy", o_tx_rdy, 0);
                check(o_count === 3'd4,  "t4_count_full", o_count, 4);
                check(o_overflow === 1'b0, "t4_no_overflow_yet", o_overflow, 0);
            end
            if (k == 5) begin
                check(o_count === 3'd4,    "t4_count_after_drop", o_count,    4);
                check(o_overflow === 1'b1, "t4_overflow",         o_overflow, 1);
            end
        end
        wr_en = 1'b0;
        wait_idle(10000, "t4");
        check(o_overflow === 1'b1, "t4_overflow_sticky", o_overflow, 1);

        // Reset during data bit 3 of 0x3C, then a clean 0xA5 frame
        write_byte(8'h3C, wc);
        push_exp({2'b00, 1'b1, 8'h3C, 1'b0}, 10, 109, 1'b0, 1'b1, wc);
        repeat (2 + 4 * 109 + 50) @(posedge clk);
        #1;
        abort = 1'b1;
        reset = 1'b1;
        @(posedge clk); #1;
        check(o_tx === 1'b1,       "t5_rst_tx",       o_tx,       1);
        check(o_busy === 1'b0,     "t5_rst_busy",     o_busy,     0);
        check(o_count === 3'd0,    "t5_rst_count",    o_count,    0);
        check(o_empty === 1'b1,    "t5_rst_empty",    o_empty,    1);
        check(o_overflow === 1'b0, "t5_rst_overflow", o_overflow, 0);
        reset = 1'b0;
        @(posedge clk); #1;
        abort = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check(o_tx === 1'b1, "t5_tx_idle_after_reset", o_tx, 1);
        write_byte(8'hA5, wc);
        push_exp({2'b00, 1'b1, 8'hA5, 1'b0}, 10, 109, 1'b0, 1'b1, wc);
        wait_idle(5000, "t5");

        // Baud 8 -> 4 mid-frame: queued frame uses 10417 clocks/bit
        baud = 4'd8;
        write_byte(8'h55, wc);
        push_exp({2'b00, 1'b1, 8'h55, 1'b0}, 10, 868, 1'b0, 1'b1, wc);
        write_byte(8'hC3, wc);
        push_exp({2'b00, 1'b1, 8'hC3, 1'b0}, 10, 10417, 1'b1, 1'b0, wc);
        check(o_count === 3'd1, "t6_count_queued", o_count, 1);
        repeat (100) @(posedge clk);
        #1;
        baud = 4'd4;
        // Start bit and first data bit of the slow frame complete before the abort
        repeat (8682 + 26000 - 101) @(posedge clk);
        #1;
        check(mon_active == 1'b1, "t6_slow_frame_in_progress", mon_active, 1);
        abort = 1'b1;
        reset = 1'b1;
        @(posedge clk); #1;
        check(o_tx === 1'b1,   "t6_rst_tx",   o_tx,   1);
        check(o_busy === 1'b0, "t6_rst_busy", o_busy, 0);
        reset = 1'b0;
        @(posedge clk); #1;
        abort = 1'b0;
        repeat (3) @(posedge clk);
        check(sb_q.size() == 0, "t6_scoreboard_drained", sb_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
